// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, datapath
// select codes, FSM states and the decoded control bundle.
package cu_pkg;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9;

    localparam logic [3:0] BR_BEQ = 4'd0, BR_BNE = 4'd1, BR_BLT = 4'd2, BR_BGE = 4'd3,
                           BR_JAL = 4'd4, BR_JALR = 4'd5, BR_BLTU = 4'd6, BR_BGEU = 4'd7,
                           BR_NONE = 4'd8;

    localparam logic [2:0] LSU_LB = 3'd0, LSU_LH = 3'd1, LSU_LW = 3'd2, LSU_LBU = 3'd3,
                           LSU_LHU = 3'd4, LSU_SB = 3'd5, LSU_SH = 3'd6, LSU_SW = 3'd7;

    localparam logic [1:0] MEM_NONE = 2'd0, MEM_STORE = 2'd1, MEM_LOAD = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0, IMM_B = 3'd1, IMM_S = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;

    localparam logic [2:0] RS1_REG = 3'd0, RS1_PC = 3'd1;
    localparam logic [2:0] RS2_REG = 3'd0, RS2_IMM = 3'd1;
    localparam logic [2:0] RD_ALU = 3'd0, RD_LSU = 3'd1, RD_IMM = 3'd2, RD_PC4 = 3'd4;
    localparam logic [2:0] PC_ADD = 3'd0, PC_ALU = 3'd1;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXECUTE, MEM_WAIT, WRITEBACK, TRAP
    } state_t;

    typedef struct packed {
        logic       illegal;
        logic       reg_write;
        logic [3:0] alu_opt;
        logic [3:0] br_opt;
        logic [2:0] lsu_opt;
        logic [1:0] mem_op;
        logic [2:0] imm_type;
        logic [2:0] rs1_sel;
        logic [2:0] rs2_sel;
        logic [2:0] reg_sel;
        logic [2:0] pc_sel;
    } ctrl_t;

    // alt selects sub/sra; callers gate it so addi never becomes a subtract.
    function automatic logic [3:0] alu_of(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational RV32I decoder: opcode/funct fields in, control bundle and
// illegal flag out. Register addresses are taken straight from the word by the top.
module cu_decode
    import cu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output ctrl_t      ctrl
);

    logic funct7_ok;
    assign funct7_ok = (funct7 == 7'h00) || (funct7 == 7'h20);

    always_comb begin
        ctrl        = '0;
        ctrl.br_opt = BR_NONE;
        case (opcode)
            OP_REG: begin
                ctrl.alu_opt   = alu_of(funct3, funct7[5]);
                ctrl.reg_write = 1'b1;
                ctrl.illegal   = !funct7_ok;
            end
            OP_IMM: begin
                ctrl.alu_opt   = alu_of(funct3, (funct3 == 3'd5) && funct7[5]);
                ctrl.rs2_sel   = RS2_IMM;
                ctrl.reg_write = 1'b1;
                ctrl.illegal   = ((funct3 == 3'd1) || (funct3 == 3'd5)) && !funct7_ok;
            end
            OP_LUI: begin
                ctrl.imm_type  = IMM_U;
                ctrl.reg_sel   = RD_IMM;
                ctrl.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                ctrl.imm_type  = IMM_U;
                ctrl.rs1_sel   = RS1_PC;
                ctrl.rs2_sel   = RS2_IMM;
                ctrl.reg_write = 1'b1;
            end
            OP_JAL: begin
                ctrl.imm_type  = IMM_J;
                ctrl.br_opt    = BR_JAL;
                ctrl.reg_sel   = RD_PC4;
                ctrl.reg_write = 1'b1;
            end
            OP_JALR: begin
                ctrl.br_opt    = BR_JALR;
                ctrl.rs2_sel   = RS2_IMM;
                ctrl.pc_sel    = PC_ALU;
                ctrl.reg_sel   = RD_PC4;
                ctrl.reg_write = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.imm_type = IMM_B;
                case (funct3)
                    3'd0:    ctrl.br_opt = BR_BEQ;
                    3'd1:    ctrl.br_opt = BR_BNE;
                    3'd4:    ctrl.br_opt = BR_BLT;
                    3'd5:    ctrl.br_opt = BR_BGE;
                    3'd6:    ctrl.br_opt = BR_BLTU;
                    3'd7:    ctrl.br_opt = BR_BGEU;
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                ctrl.rs2_sel   = RS2_IMM;
                ctrl.reg_sel   = RD_LSU;
                ctrl.mem_op    = MEM_LOAD;
                ctrl.reg_write = 1'b1;
                case (funct3)
                    3'd0:    ctrl.lsu_opt = LSU_LB;
                    3'd1:    ctrl.lsu_opt = LSU_LH;
                    3'd2:    ctrl.lsu_opt = LSU_LW;
                    3'd4:    ctrl.lsu_opt = LSU_LBU;
                    3'd5:    ctrl.lsu_opt = LSU_LHU;
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                ctrl.imm_type = IMM_S;
                ctrl.rs2_sel  = RS2_IMM;
                ctrl.mem_op   = MEM_STORE;
                case (funct3)
                    3'd0:    ctrl.lsu_opt = LSU_SB;
                    3'd1:    ctrl.lsu_opt = LSU_SH;
                    3'd2:    ctrl.lsu_opt = LSU_SW;
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            OP_FENCE: ;
            default: ctrl.illegal = 1'b1;  // includes SYSTEM
        endcase
    end

endmodule

// File: rtl/cu_mc.sv
// Multi-cycle control unit: FETCH/DECODE/EXECUTE/MEM_WAIT/WRITEBACK sequencer
// with registered datapath controls, memory-wait timeout and sticky error flags.
module cu_mc
    import cu_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int STORE_WAIT  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           mem_inst,
    input  logic                  inst_valid,
    input  logic                  read_ready,
    input  logic                  write_done,
    output logic                  inst_req,
    output logic                  pc_clk,
    output logic [REG_ADDR_W-1:0] rs1_adr,
    output logic [REG_ADDR_W-1:0] rs2_adr,
    output logic [REG_ADDR_W-1:0] reg_adr,
    output logic [3:0]            alu_opt,
    output logic [3:0]            br_opt,
    output logic [2:0]            lsu_opt,
    output logic [1:0]            mem_op,
    output logic                  write_enb,
    output logic [2:0]            imm_type,
    output logic [2:0]            rs1_mux_select,
    output logic [2:0]            rs2_mux_select,
    output logic [2:0]            reg_mux_select,
    output logic [2:0]            pc_mux_select,
    output logic                  illegal_inst,
    output logic                  mem_timeout_err,
    output logic                  busy,
    output state_t                fsm_state
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

    state_t          state;
    logic [31:0]     inst_q;
    logic [CW-1:0]   wait_cnt;
    ctrl_t           ctrl;
    logic            needs_wait;
    logic            handshake;
    logic            rd_write;

    cu_decode u_decode (
        .opcode (inst_q[6:0]),
        .funct3 (inst_q[14:12]),
        .funct7 (inst_q[31:25]),
        .ctrl   (ctrl)
    );

    // Handshakes are level-sampled on each rising edge: inst_valid only in FETCH,
    // read_ready only for a load and write_done only for a store, both in MEM_WAIT.
    assign needs_wait = (ctrl.mem_op == MEM_LOAD) || ((ctrl.mem_op == MEM_STORE) && (STORE_WAIT != 0));
    assign handshake  = ((ctrl.mem_op == MEM_LOAD) && read_ready) ||
                        ((ctrl.mem_op == MEM_STORE) && write_done);
    assign rd_write   = ctrl.reg_write && (inst_q[7 +: REG_ADDR_W] != '0);
    assign fsm_state  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            inst_q          <= '0;
            wait_cnt        <= '0;
            inst_req        <= 1'b0;
            pc_clk          <= 1'b0;
            rs1_adr         <= '0;
            rs2_adr         <= '0;
            reg_adr         <= '0;
            alu_opt         <= ALU_ADD;
            br_opt          <= BR_NONE;
            lsu_opt         <= '0;
            mem_op          <= MEM_NONE;
            write_enb       <= 1'b0;
            imm_type        <= '0;
            rs1_mux_select  <= '0;
            rs2_mux_select  <= '0;
            reg_mux_select  <= '0;
            pc_mux_select   <= '0;
            illegal_inst    <= 1'b0;
            mem_timeout_err <= 1'b0;
            busy            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    inst_req <= 1'b1;
                end
                FETCH: begin
                    if (inst_valid) begin
                        inst_q   <= mem_inst;
                        state    <= DECODE;
                        inst_req <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                DECODE: begin
                    rs1_adr        <= inst_q[15 +: REG_ADDR_W];
                    rs2_adr        <= inst_q[20 +: REG_ADDR_W];
                    reg_adr        <= inst_q[7 +: REG_ADDR_W];
                    alu_opt        <= ctrl.alu_opt;
                    br_opt         <= ctrl.br_opt;
                    lsu_opt        <= ctrl.lsu_opt;
                    imm_type       <= ctrl.imm_type;
                    rs1_mux_select <= ctrl.rs1_sel;
                    rs2_mux_select <= ctrl.rs2_sel;
                    reg_mux_select <= ctrl.reg_sel;
                    pc_mux_select  <= ctrl.pc_sel;
                    if (ctrl.illegal) begin
                        state        <= TRAP;
                        illegal_inst <= 1'b1;
                    end else begin
                        state  <= EXECUTE;
                        // A non-waiting store shows MEM_OP only during EXECUTE.
                        mem_op <= needs_wait ? MEM_NONE : ctrl.mem_op;
                    end
                end
                EXECUTE: begin
                    wait_cnt <= '0;
                    if (needs_wait) begin
                        state  <= MEM_WAIT;
                        mem_op <= ctrl.mem_op;
                    end else begin
                        state     <= WRITEBACK;
                        mem_op    <= MEM_NONE;
                        pc_clk    <= 1'b1;
                        write_enb <= rd_write;
                    end
                end
                MEM_WAIT: begin
                    if (handshake) begin
                        state     <= WRITEBACK;
                        mem_op    <= MEM_NONE;
                        pc_clk    <= 1'b1;
                        write_enb <= rd_write;
                    end else if ((MEM_TIMEOUT != 0) && (wait_cnt == LIMIT)) begin
                        state           <= TRAP;
                        mem_op          <= MEM_NONE;
                        mem_timeout_err <= 1'b1;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WRITEBACK: begin
                    state     <= FETCH;
                    pc_clk    <= 1'b0;
                    write_enb <= 1'b0;
                    inst_req  <= 1'b1;
                    busy      <= 1'b0;
                end
                TRAP: begin
                    pc_clk    <= 1'b0;
                    write_enb <= 1'b0;
                    mem_op    <= MEM_NONE;
                    inst_req  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cu_mc.sv
// Bench for cu_mc: random instruction stream scored against a table-driven
// reference decoder, plus directed timeout, illegal-decode and reset scenarios.
module tb_cu_mc;
    import cu_pkg::*;

    localparam int RAW = 5;
    localparam int TMO = 15;
    localparam int SWT = 1;

    logic           clk;
    logic           rst_n;
    logic [31:0]    mem_inst;
    logic           inst_valid;
    logic           read_ready;
    logic           write_done;
    logic           inst_req;
    logic           pc_clk;
    logic [RAW-1:0] rs1_adr, rs2_adr, reg_adr;
    logic [3:0]     alu_opt, br_opt;
    logic [2:0]     lsu_opt, imm_type;
    logic [1:0]     mem_op;
    logic           write_enb;
    logic [2:0]     rs1_mux_select, rs2_mux_select, reg_mux_select, pc_mux_select;
    logic           illegal_inst, mem_timeout_err, busy;
    state_t         fsm_state;

    cu_mc #(.REG_ADDR_W(RAW), .MEM_TIMEOUT(TMO), .STORE_WAIT(SWT)) dut (
        .clk(clk), .rst_n(rst_n), .mem_inst(mem_inst), .inst_valid(inst_valid),
        .read_ready(read_ready), .write_done(write_done), .inst_req(inst_req),
        .pc_clk(pc_clk), .rs1_adr(rs1_adr), .rs2_adr(rs2_adr), .reg_adr(reg_adr),
        .alu_opt(alu_opt), .br_opt(br_opt), .lsu_opt(lsu_opt), .mem_op(mem_op),
        .write_enb(write_enb), .imm_type(imm_type), .rs1_mux_select(rs1_mux_select),
        .rs2_mux_select(rs2_mux_select), .reg_mux_select(reg_mux_select),
        .pc_mux_select(pc_mux_select), .illegal_inst(illegal_inst),
        .mem_timeout_err(mem_timeout_err), .busy(busy), .fsm_state(fsm_state)
    );

    typedef struct packed {
        logic        illegal;
        logic [3:0]  alu;
        logic [3:0]  br;
        logic [2:0]  lsu;
        logic [1:0]  mem;
        logic        we;
        logic [2:0]  imm;
        logic [2:0]  s1, s2, sr, ps;
        logic [4:0]  rd, rs1, rs2;
        logic [7:0]  lat;
        logic [31:0] issue;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   mem_n = 0;
    int   hold = 0;
    int   hold_val = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference decode from the ISA tables, independent of how the RTL is built.
    function automatic exp_t model(input logic [31:0] w, input int n);
        exp_t e;
        int op_alu [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int br_map [8] = '{0, 1, -1, -1, 2, 3, 6, 7};
        int ld_map [8] = '{0, 1, 2, -1, 3, 4, -1, -1};
        int st_map [8] = '{5, 6, 7, -1, -1, -1, -1, -1};
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        logic       f7_std = (f7 == 7'h00) || (f7 == 7'h20);
        logic       writes = 1'b0;
        e     = '0;
        e.br  = 4'd8;
        e.rd  = w[11:7];
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        case (w[6:0])
            7'h33: begin
                e.alu = 4'(op_alu[f3]);
                if (f7 == 7'h20 && f3 == 3'd0) e.alu = 4'd1;
                if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'd7;
                e.illegal = !f7_std;
                writes = 1'b1;
            end
            7'h13: begin
                e.alu = 4'(op_alu[f3]);
                if (f3 == 3'd5 && f7[5]) e.alu = 4'd7;
                if ((f3 == 3'd1 || f3 == 3'd5) && !f7_std) e.illegal = 1'b1;
                e.s2 = 3'd1;
                writes = 1'b1;
            end
            7'h37: begin e.imm = 3'd3; e.sr = 3'd2; writes = 1'b1; end
            7'h17: begin e.imm = 3'd3; e.s1 = 3'd1; e.s2 = 3'd1; writes = 1'b1; end
            7'h6F: begin e.imm = 3'd4; e.br = 4'd4; e.sr = 3'd4; writes = 1'b1; end
            7'h67: begin e.br = 4'd5; e.s2 = 3'd1; e.ps = 3'd1; e.sr = 3'd4; writes = 1'b1; end
            7'h63: begin
                e.imm = 3'd1;
                if (br_map[f3] < 0) e.illegal = 1'b1; else e.br = 4'(br_map[f3]);
            end
            7'h03: begin
                if (ld_map[f3] < 0) e.illegal = 1'b1; else e.lsu = 3'(ld_map[f3]);
                e.s2 = 3'd1; e.sr = 3'd1; e.mem = 2'd2; writes = 1'b1;
            end
            7'h23: begin
                if (st_map[f3] < 0) e.illegal = 1'b1; else e.lsu = 3'(st_map[f3]);
                e.imm = 3'd2; e.s2 = 3'd1; e.mem = 2'd1;
            end
            7'h0F: ;
            default: e.illegal = 1'b1;
        endcase
        e.we  = writes && (e.rd != 5'd0);
        e.lat = (e.mem != 2'd0) ? 8'(3 + n) : 8'd3;
        return e;
    endfunction

    function automatic logic [31:0] gen_word();
        logic [4:0]  rd  = 5'($urandom_range(0, 31));
        logic [4:0]  rs1 = 5'($urandom_range(0, 31));
        logic [4:0]  rs2 = 5'($urandom_range(0, 31));
        logic [31:0] r   = $urandom();
        logic [6:0]  f7  = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        logic [2:0]  f3  = 3'($urandom_range(0, 7));
        int bl [6] = '{0, 1, 4, 5, 6, 7};
        int ll [5] = '{0, 1, 2, 4, 5};
        case ($urandom_range(0, 9))
            0: return {f7, rs2, rs1, f3, rd, 7'h33};
            1: begin
                if (f3 == 3'd1 || f3 == 3'd5) return {f7, rs2, rs1, f3, rd, 7'h13};
                return {r[11:0], rs1, f3, rd, 7'h13};
            end
            2: return {r[19:0], rd, 7'h37};
            3: return {r[19:0], rd, 7'h17};
            4: return {r[19:0], rd, 7'h6F};
            5: return {r[11:0], rs1, 3'b000, rd, 7'h67};
            6: return {r[6:0], rs2, rs1, 3'(bl[$urandom_range(0, 5)]), r[11:7], 7'h63};
            7: return {r[11:0], rs1, 3'(ll[$urandom_range(0, 4)]), rd, 7'h03};
            8: return {r[6:0], rs2, rs1, 3'($urandom_range(0, 2)), r[11:7], 7'h23};
            default: return {r[31:7], 7'h0F};
        endcase
    endfunction

    // driver tasks
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (inst_req) begin
                ok = 1'b1;
                return;
            end
        end
        chk("inst_req_wait", 32'(inst_req), 32'd1);
    endtask

    task automatic issue(input logic [31:0] w, input int n, input bit scored, output bit ok, output int icyc);
        exp_t e;
        wait_req(ok);
        icyc = cyc;
        if (!ok) return;
        mem_n = n;
        if (scored) begin
            e = model(w, n);
            e.issue = 32'(cyc);
            exp_q.push_back(e);
        end
        mem_inst   = w;
        inst_valid = 1'b1;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        mem_inst   = $urandom();
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_state"}, 32'(fsm_state), 32'(IDLE));
        chk({nm, "_br_opt"}, 32'(br_opt), 32'd8);
        chk({nm, "_strobes"}, {28'd0, inst_req, pc_clk, write_enb, busy}, 32'd0);
        chk({nm, "_mem_op"}, 32'(mem_op), 32'd0);
        chk({nm, "_flags"}, {30'd0, illegal_inst, mem_timeout_err}, 32'd0);
        chk({nm, "_fields"}, {alu_opt, lsu_opt, imm_type, rs1_adr, rs2_adr, reg_adr}, 32'd0);
        chk({nm, "_muxes"}, {20'd0, rs1_mux_select, rs2_mux_select, reg_mux_select, pc_mux_select}, 32'd0);
    endtask

    task automatic apply_reset(input string nm);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle(nm);
        repeat (2) @(negedge clk);
        exp_q.delete();
        hold = 0;
        hold_val = 0;
    endtask

    task automatic release_reset(input string nm);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({nm, "_rel_state"}, 32'(fsm_state), 32'(IDLE));
        chk({nm, "_rel_inst_req"}, 32'(inst_req), 32'd0);
        @(negedge clk);
        chk({nm, "_fetch_state"}, 32'(fsm_state), 32'(FETCH));
        chk({nm, "_fetch_inst_req"}, 32'(inst_req), 32'd1);
        chk({nm, "_fetch_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_trap(input string nm, input logic ill, input logic tmo);
        chk({nm, "_state"}, 32'(fsm_state), 32'(TRAP));
        chk({nm, "_flags"}, {30'd0, illegal_inst, mem_timeout_err}, {30'd0, ill, tmo});
        chk({nm, "_strobes"}, {28'd0, inst_req, pc_clk, write_enb, busy}, 32'd1);
        chk({nm, "_mem_op"}, 32'(mem_op), 32'd0);
    endtask

    // memory responder: handshake in the mem_n-th MEM_WAIT cycle, noise on the other strobe
    initial begin
        int wc = 0;
        read_ready = 1'b0;
        write_done = 1'b0;
        forever begin
            @(negedge clk);
            read_ready = 1'b0;
            write_done = 1'b0;
            if (rst_n && mem_op != 2'd0) begin
                wc = wc + 1;
                if (mem_n != 0 && wc == mem_n) begin
                    if (mem_op == 2'd2) read_ready = 1'b1;
                    else write_done = 1'b1;
                end else if (mem_op == 2'd2) begin
                    write_done = 1'($urandom_range(0, 1));
                end else begin
                    read_ready = 1'($urandom_range(0, 1));
                end
            end else begin
                wc = 0;
            end
        end
    end

    // scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_op != 2'd0) begin
                    hold = hold + 1;
                    hold_val = int'(mem_op);
                end
                if (write_enb && !pc_clk) chk("write_enb_without_pc_clk", 32'(write_enb), 32'd0);
                if (pc_clk) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pc_clk", 32'(pc_clk), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("latency", 32'(cyc) - e.issue, 32'(e.lat));
                        chk("write_enb", 32'(write_enb), 32'(e.we));
                        chk("alu_opt", 32'(alu_opt), 32'(e.alu));
                        chk("br_opt", 32'(br_opt), 32'(e.br));
                        chk("lsu_opt", 32'(lsu_opt), 32'(e.lsu));
                        chk("imm_type", 32'(imm_type), 32'(e.imm));
                        chk("muxes", {20'd0, rs1_mux_select, rs2_mux_select, reg_mux_select, pc_mux_select},
                            {20'd0, e.s1, e.s2, e.sr, e.ps});
                        chk("reg_addrs", {17'd0, rs1_adr, rs2_adr, reg_adr}, {17'd0, e.rs1, e.rs2, e.rd});
                        chk("mem_op_hold_cycles", 32'(hold), (e.mem != 2'd0) ? 32'(e.lat) - 32'd3 : 32'd0);
                        chk("mem_op_value", 32'(hold_val), 32'(e.mem));
                        chk("writeback_mem_op", 32'(mem_op), 32'd0);
                        chk("writeback_busy", 32'(busy), 32'd1);
                    end
                    hold = 0;
                    hold_val = 0;
                end
            end
        end
    end

    // stimulus
    initial begin
        bit ok;
        int ic;
        logic [31:0] w;
        logic [31:0] ill_words [4] = '{32'h0000007F, 32'h022081B3, 32'h00000073, 32'h0080B283};
        rst_n      = 1'b0;
        mem_inst   = '0;
        inst_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("por");
        release_reset("por");

        issue(32'h002081B3, 0, 1'b1, ok, ic);   // add x3,x1,x2
        issue(32'h0080A283, 4, 1'b1, ok, ic);   // lw x5,8(x1), ready in 4th wait cycle
        issue(32'h00100013, 0, 1'b1, ok, ic);   // addi x0,x0,1
        issue(32'h00112423, 1, 1'b1, ok, ic);   // sw x1,8(x2), immediate accept
        issue(32'h0080A283, TMO, 1'b1, ok, ic); // handshake on the last allowed cycle
        issue(32'h0000000F, 0, 1'b1, ok, ic);   // fence
        for (int i = 0; i < 60; i++) begin
            w = gen_word();
            issue(w, (w[6:0] == 7'h03 || w[6:0] == 7'h23) ? $urandom_range(1, TMO) : 0, 1'b1, ok, ic);
            if (!ok) break;
        end
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);

        // store never accepted
        issue(32'h00112423, 0, 1'b0, ok, ic);
        for (int i = 0; i < 40 && cyc < ic + 2 + TMO; i++) @(negedge clk);
        chk("timeout_pre_state", 32'(fsm_state), 32'(MEM_WAIT));
        chk("timeout_pre_err", 32'(mem_timeout_err), 32'd0);
        @(negedge clk);
        check_trap("timeout", 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check_trap("timeout_hold", 1'b0, 1'b1);
        apply_reset("timeout_rst");
        release_reset("timeout_rst");

        for (int k = 0; k < 4; k++) begin
            issue(ill_words[k], 0, 1'b0, ok, ic);
            repeat (4) @(negedge clk);
            check_trap($sformatf("illegal%0d", k), 1'b1, 1'b0);
            if (k == 0) begin
                repeat (10) @(negedge clk);
                check_trap("illegal_sticky", 1'b1, 1'b0);
            end
            apply_reset($sformatf("illegal%0d_rst", k));
            release_reset($sformatf("illegal%0d_rst", k));
        end

        // reset while a load is stuck in MEM_WAIT
        issue(32'h0080A283, 0, 1'b0, ok, ic);
        repeat (5) @(negedge clk);
        chk("midload_mem_op", 32'(mem_op), 32'd2);
        chk("midload_state", 32'(fsm_state), 32'(MEM_WAIT));
        apply_reset("midload_rst");
        release_reset("midload_rst");
        issue(32'h002081B3, 0, 1'b1, ok, ic);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("post_reset_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
